// File: rtl/prime_serializer.sv
// prime_serializer: captures a candidate that miller_rabin reports as prime
// and streams it out LSB-chunk first as CHUNK-bit words over valid/ready.
// A one-cycle search_restart pulse follows the final accepted word.
//
// Optional feature macro: PRIME_SER_CHECKSUM_EN
//   When defined, an extra word carrying the XOR of all data chunks follows
//   the data words, and out_last moves onto that checksum word.
//
// Handshake: a word transfers on a rising clk edge where out_valid and
// out_ready are both 1. Once out_valid rises it stays high, with out_data
// and out_last stable, until that transfer happens.
module prime_serializer #(
    parameter int WORDSIZE = 272,
    parameter int CHUNK    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [WORDSIZE-1:0] cand_in,
    input  logic                mr_finish,
    input  logic                mr_prime,
    output logic [CHUNK-1:0]    out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last,
    output logic                busy,
    output logic                search_restart,
    output logic [15:0]         prime_count,
    output logic [7:0]          drop_count,
    output logic [1:0]          state_dbg
);

    localparam int NUM_CHUNKS = WORDSIZE / CHUNK;
    // Index must be able to reach NUM_CHUNKS (the checksum slot) plus one.
    localparam int IDX_W      = $clog2(NUM_CHUNKS + 2);
`ifdef PRIME_SER_CHECKSUM_EN
    localparam int LAST_IDX   = NUM_CHUNKS;
`else
    localparam int LAST_IDX   = NUM_CHUNKS - 1;
`endif
    localparam logic [IDX_W-1:0] LAST_IDX_V = IDX_W'(LAST_IDX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [WORDSIZE-1:0] shift_q;
    logic [IDX_W-1:0]    idx_q;
    logic [15:0]         prime_cnt_q;
    logic [7:0]          drop_cnt_q;
`ifdef PRIME_SER_CHECKSUM_EN
    logic [CHUNK-1:0]    csum_q;
`endif

    logic prime_hit;
    logic xfer;
    logic is_last;

    assign prime_hit = mr_finish & mr_prime;
    assign xfer      = (state_q == SEND) & out_ready;
    assign is_last   = (idx_q == LAST_IDX_V);

    // Next-state selection for the IDLE -> SEND -> DONE cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (prime_hit) state_d = SEND;
            SEND:    if (xfer && is_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode; data is forced to zero outside SEND so stale bits never leak.
    always_comb begin
        out_valid      = (state_q == SEND);
        out_last       = (state_q == SEND) && is_last;
        busy           = (state_q != IDLE);
        search_restart = (state_q == DONE);
        out_data       = '0;
        if (state_q == SEND) begin
            out_data = shift_q[CHUNK-1:0];
`ifdef PRIME_SER_CHECKSUM_EN
            if (idx_q == IDX_W'(NUM_CHUNKS)) out_data = csum_q;
`endif
        end
    end

    // State register, capture/shift datapath and the two event counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            idx_q       <= '0;
            prime_cnt_q <= '0;
            drop_cnt_q  <= '0;
`ifdef PRIME_SER_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && prime_hit) begin
                shift_q     <= cand_in;
                idx_q       <= '0;
                prime_cnt_q <= prime_cnt_q + 16'd1;
`ifdef PRIME_SER_CHECKSUM_EN
                csum_q      <= '0;
`endif
            end else if (xfer) begin
                shift_q <= shift_q >> CHUNK;
                idx_q   <= idx_q + IDX_W'(1);
`ifdef PRIME_SER_CHECKSUM_EN
                // The checksum word itself also lands here, but DONE follows
                // immediately so the extra XOR is never observed.
                csum_q  <= csum_q ^ shift_q[CHUNK-1:0];
`endif
            end
            // A prime verdict while a previous prime is still in flight is lost.
            if (prime_hit && state_q != IDLE && drop_cnt_q != 8'd255)
                drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

    assign prime_count = prime_cnt_q;
    assign drop_count  = drop_cnt_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_prime_serializer.sv
// Directed testbench for prime_serializer: a 48-bit instance for the
// handshake, stall, ignore, drop and reset scenarios, and a default 272-bit
// instance for the full-width reassembly check.
module tb_prime_serializer;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // 48-bit instance
    logic [47:0] cand_a;
    logic        fin_a, prime_a, ready_a;
    logic [15:0] data_a;
    logic        valid_a, last_a, busy_a, restart_a;
    logic [15:0] pc_a;
    logic [7:0]  dc_a;
    logic [1:0]  st_a;

    // 272-bit instance
    logic [271:0] cand_b;
    logic         fin_b, prime_b, ready_b;
    logic [15:0]  data_b;
    logic         valid_b, last_b, busy_b, restart_b;
    logic [15:0]  pc_b;
    logic [7:0]   dc_b;
    logic [1:0]   st_b;

    prime_serializer #(.WORDSIZE(48), .CHUNK(16)) dut_a (
        .clk(clk), .reset(reset), .cand_in(cand_a), .mr_finish(fin_a),
        .mr_prime(prime_a), .out_data(data_a), .out_valid(valid_a),
        .out_ready(ready_a), .out_last(last_a), .busy(busy_a),
        .search_restart(restart_a), .prime_count(pc_a), .drop_count(dc_a),
        .state_dbg(st_a)
    );

    prime_serializer dut_b (
        .clk(clk), .reset(reset), .cand_in(cand_b), .mr_finish(fin_b),
        .mr_prime(prime_b), .out_data(data_b), .out_valid(valid_b),
        .out_ready(ready_b), .out_last(last_b), .busy(busy_b),
        .search_restart(restart_b), .prime_count(pc_b), .drop_count(dc_b),
        .state_dbg(st_b)
    );

    // ---------------- scoreboard ----------------
    logic [15:0] exp_q[$];
    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are read there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic strobe_a(input logic [47:0] cand);
        cand_a  = cand;
        fin_a   = 1'b1;
        prime_a = 1'b1;
        tick();
        fin_a   = 1'b0;
        prime_a = 1'b0;
    endtask

    // Queue the expected word stream for a 48-bit candidate.
    task automatic push_words_a(input logic [47:0] cand);
        logic [15:0] x;
        x = 16'h0;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(cand[16*k +: 16]);
            x ^= cand[16*k +: 16];
        end
`ifdef PRIME_SER_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    // Consume the queued stream from dut_a; optionally hold out_ready low
    // for stall_len cycles while word stall_at is presented.
    task automatic drain_a(input int stall_at, input int stall_len);
        logic [15:0] e;
        int w;
        w = 0;
        while (exp_q.size() > 0) begin
            if (w == stall_at) begin
                ready_a = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    check("stall_valid", valid_a, 1);
                    check("stall_data", data_a, exp_q[0]);
                    tick();
                end
                ready_a = 1'b1;
            end
            e = exp_q.pop_front();
            check("a_valid", valid_a, 1);
            check("a_data", data_a, e);
            check("a_last", last_a, (exp_q.size() == 0));
            tick();
            w++;
        end
        check("a_restart_pulse", restart_a, 1);
        check("a_done_valid", valid_a, 0);
        check("a_done_busy", busy_a, 1);
        tick();
        check("a_restart_end", restart_a, 0);
        check("a_idle_busy", busy_a, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [271:0] rebuilt;
        logic [15:0]  x;
        logic [15:0]  e;
        int           w;

        reset = 1'b0;
        cand_a = '0; fin_a = 0; prime_a = 0; ready_a = 1;
        cand_b = '0; fin_b = 0; prime_b = 0; ready_b = 1;
        tick();
        tick();
        check("rst_valid", valid_a, 0);
        check("rst_data", data_a, 0);
        check("rst_last", last_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_restart", restart_a, 0);
        check("rst_pc", pc_a, 0);
        check("rst_dc", dc_a, 0);
        check("rst_state", st_a, 0);
        reset = 1'b1;
        tick();

        // Non-prime verdicts are ignored.
        cand_a = 48'h1234_5678_9abc;
        for (int i = 0; i < 10; i++) begin
            fin_a = 1'b1; prime_a = 1'b0;
            tick();
            check("np_valid", valid_a, 0);
        end
        fin_a = 1'b0;
        tick();
        check("np_pc", pc_a, 0);
        check("np_dc", dc_a, 0);

        // Basic stream, ready always high.
        push_words_a(48'h0004_0002_0001);
        strobe_a(48'h0004_0002_0001);
        drain_a(-1, 0);
        check("basic_pc", pc_a, 1);

        // Same candidate with a 5-cycle stall on the second word.
        push_words_a(48'h0004_0002_0001);
        strobe_a(48'h0004_0002_0001);
        drain_a(1, 5);
        check("stall_pc", pc_a, 2);

        // Capture, then 300 further prime strobes while stalled in SEND.
        ready_a = 1'b0;
        strobe_a(48'hbeef_cafe_f00d);
        cand_a = 48'h1111_2222_3333;
        fin_a = 1'b1; prime_a = 1'b1;
        repeat (300) tick();
        fin_a = 1'b0; prime_a = 1'b0;
        check("drop_dc", dc_a, 255);
        check("drop_pc", pc_a, 3);
        ready_a = 1'b1;
        push_words_a(48'hbeef_cafe_f00d);
        drain_a(-1, 0);

        // Reset mid-SEND after one word has transferred.
        strobe_a(48'h0004_0002_0001);
        check("mid_w0", data_a, 16'h0001);
        tick();
        check("mid_w1", data_a, 16'h0002);
        reset = 1'b0;
        tick();
        check("mrst_valid", valid_a, 0);
        check("mrst_data", data_a, 0);
        check("mrst_last", last_a, 0);
        check("mrst_busy", busy_a, 0);
        check("mrst_restart", restart_a, 0);
        check("mrst_state", st_a, 0);
        check("mrst_pc", pc_a, 0);
        check("mrst_dc", dc_a, 0);
        reset = 1'b1;
        tick();
        check("mrst_no_restart", restart_a, 0);
        push_words_a(48'h0030_0020_0010);
        strobe_a(48'h0030_0020_0010);
        drain_a(-1, 0);
        check("fresh_pc", pc_a, 1);

        // Full-width instance: random candidate, reassembled LSB chunk first.
        x = 16'h0;
        for (int k = 0; k < 17; k++) begin
            cand_b[16*k +: 16] = 16'($urandom_range(0, 65535));
            exp_q.push_back(cand_b[16*k +: 16]);
            x ^= cand_b[16*k +: 16];
        end
`ifdef PRIME_SER_CHECKSUM_EN
        exp_q.push_back(x);
`endif
        fin_b = 1'b1; prime_b = 1'b1;
        tick();
        fin_b = 1'b0; prime_b = 1'b0;
        rebuilt = '0;
        w = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("b_valid", valid_b, 1);
            check("b_data", data_b, e);
            check("b_last", last_b, (exp_q.size() == 0));
            if (w < 17) rebuilt[16*w +: 16] = data_b;
            tick();
            w++;
        end
        check("b_rebuilt", (rebuilt == cand_b), 1);
        check("b_restart", restart_b, 1);
        tick();
        check("b_idle", busy_b, 0);
        check("b_pc", pc_b, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
